// File: rtl/keypad_pkg.sv
// Shared constants and types for the keypad scanner and its bus slot.
package keypad_pkg;

   localparam logic ADDR_DATA   = 1'b0;
   localparam logic ADDR_STATUS = 1'b1;

   localparam int unsigned ST_NOT_EMPTY = 7;
   localparam int unsigned ST_OVERFLOW  = 6;
   localparam int unsigned ST_IRQ_EN    = 5;

   localparam logic [7:0] KEY_CODE_BASE = 8'h10;

   typedef enum logic [1:0] {
      RELEASED     = 2'd0,
      PRESS_PEND   = 2'd1,
      HELD         = 2'd2,
      RELEASE_PEND = 2'd3
   } deb_state_t;

   // Code = base + 4*row + col, which is just {row, col} above the base.
   function automatic logic [7:0] key_code(input logic [1:0] row_idx, input logic [1:0] col_idx);
      return KEY_CODE_BASE + 8'({row_idx, col_idx});
   endfunction

endpackage

// File: rtl/keypad_fifo.sv
// Small key-code queue; a push into a full queue only lands if a pop frees a slot the same edge.
module keypad_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic [WIDTH-1:0]             din,
   input  logic                         pop,
   output logic [WIDTH-1:0]             dout,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         full,
   output logic                         empty
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic             do_pop;
   logic             do_push;

   // Pop on empty is ignored; push on full needs a real pop alongside.
   always_comb begin
      do_pop  = pop && !empty;
      do_push = push && (!full || do_pop);
   end

   // Storage is not reset; the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // Pointer and occupancy tracking with explicit wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
         if (do_push && !do_pop)      count <= count + CW'(1);
         else if (do_pop && !do_push) count <= count - CW'(1);
      end
   end

   // Head and flags straight from the registers.
   always_comb begin
      dout  = mem[rd_ptr];
      full  = (count == CW'(DEPTH));
      empty = (count == '0);
   end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad column scanner, sweep debouncer and two-register CPU slot.
module keypad_scan_ctrl
   import keypad_pkg::*;
#(
   parameter int unsigned SCAN_DIV   = 100000,
   parameter int unsigned DEBOUNCE   = 3,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] row,
   output logic [3:0] col,
   input  logic       cs,
   input  logic       rd,
   input  logic       wr,
   input  logic       addr,
   input  logic [7:0] wdata,
   output logic [7:0] rdata,
   output logic       irq
);

   localparam int unsigned SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned CNT_W  = $clog2(DEBOUNCE + 1);
   localparam int unsigned FCW    = $clog2(FIFO_DEPTH + 1);

   logic [SLOT_W-1:0] slot_cnt;
   logic [1:0]        col_idx;
   logic              slot_end;
   logic              sweep_end;

   logic [1:0]        acc_hits;
   logic [3:0]        acc_code;
   logic [2:0]        row_hits;
   logic [1:0]        row_sel;
   logic [2:0]        hit_sum;
   logic [1:0]        merged_hits;
   logic [3:0]        merged_code;
   logic              sweep_key;
   logic [7:0]        sweep_code;

   deb_state_t        state, state_n;
   logic [7:0]        cand, cand_n;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic              push_c;
   logic              match;

   logic              rd_act, wr_act, pop_c, status_wr, drop;
   logic              overflow, irq_en;
   logic [7:0]        status;
   logic [7:0]        fifo_dout;
   logic [FCW-1:0]    fifo_count;
   logic              fifo_full, fifo_empty;
   logic              unused_wdata;

   assign unused_wdata = ^{wdata[7], wdata[4:0]};

   // Slot timing and one-hot column rotation.
   always_ff @(posedge clk) begin
      if (rst) begin
         slot_cnt <= '0;
         col_idx  <= 2'd0;
         col      <= 4'b0001;
      end else if (slot_end) begin
         slot_cnt <= '0;
         col_idx  <= col_idx + 2'd1;
         col      <= {col[2:0], col[3]};
      end else begin
         slot_cnt <= slot_cnt + SLOT_W'(1);
      end
   end

   // Merge this slot's row sample into the sweep tally (hits saturate at 2 = ghost).
   always_comb begin
      slot_end  = (slot_cnt == SLOT_W'(SCAN_DIV - 1));
      sweep_end = slot_end && (col_idx == 2'd3);
      row_hits  = 3'd0;
      row_sel   = 2'd0;
      for (int i = 0; i < 4; i++) begin
         row_hits = row_hits + 3'(row[i]);
         if (row[i]) row_sel = 2'(i);
      end
      hit_sum     = 3'(acc_hits) + row_hits;
      merged_hits = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
      merged_code = (row_hits == 3'd1) ? {row_sel, col_idx} : acc_code;
      sweep_key   = (merged_hits == 2'd1);
      sweep_code  = key_code(merged_code[3:2], merged_code[1:0]);
   end

   // Sweep accumulator, cleared as each sweep resolves.
   always_ff @(posedge clk) begin
      if (rst || sweep_end) begin
         acc_hits <= 2'd0;
         acc_code <= 4'd0;
      end else if (slot_end) begin
         acc_hits <= merged_hits;
         acc_code <= merged_code;
      end
   end

   // Debounce state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RELEASED;
         cand  <= 8'h00;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cand  <= cand_n;
         cnt   <= cnt_n;
      end
   end

   // Debounce next state, evaluated only on sweep boundaries.
   always_comb begin
      state_n = state;
      cand_n  = cand;
      cnt_n   = cnt;
      push_c  = 1'b0;
      match   = sweep_key && (sweep_code == cand);
      if (sweep_end) begin
         case (state)
            RELEASED: begin
               if (sweep_key) begin
                  cand_n = sweep_code;
                  cnt_n  = CNT_W'(1);
                  if (DEBOUNCE <= 1) begin
                     push_c  = 1'b1;
                     state_n = HELD;
                  end else begin
                     state_n = PRESS_PEND;
                  end
               end
            end
            PRESS_PEND: begin
               if (match) begin
                  cnt_n = cnt + CNT_W'(1);
                  if (cnt + CNT_W'(1) == CNT_W'(DEBOUNCE)) begin
                     push_c  = 1'b1;
                     state_n = HELD;
                  end
               end else if (sweep_key) begin
                  cand_n = sweep_code;
                  cnt_n  = CNT_W'(1);
               end else begin
                  cnt_n   = '0;
                  state_n = RELEASED;
               end
            end
            HELD: begin
               if (!match) begin
                  if (DEBOUNCE <= 1) begin
                     cnt_n   = '0;
                     state_n = RELEASED;
                  end else begin
                     cnt_n   = CNT_W'(1);
                     state_n = RELEASE_PEND;
                  end
               end
            end
            RELEASE_PEND: begin
               if (match) begin
                  state_n = HELD;
               end else if (cnt + CNT_W'(1) == CNT_W'(DEBOUNCE)) begin
                  cnt_n   = '0;
                  state_n = RELEASED;
               end else begin
                  cnt_n = cnt + CNT_W'(1);
               end
            end
            default: state_n = RELEASED;
         endcase
      end
   end

   keypad_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_c),
      .din   (cand_n),
      .pop   (pop_c),
      .dout  (fifo_dout),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Bus decode; a read strobe masks any simultaneous write.
   always_comb begin
      rd_act    = cs && rd;
      wr_act    = cs && wr && !rd;
      pop_c     = rd_act && (addr == ADDR_DATA);
      status_wr = wr_act && (addr == ADDR_STATUS);
      drop      = push_c && fifo_full && !pop_c;
   end

   // Control bits; a drop in the same cycle beats a software clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow <= 1'b0;
         irq_en   <= 1'b0;
      end else begin
         if (status_wr) irq_en <= wdata[ST_IRQ_EN];
         if (drop)                                overflow <= 1'b1;
         else if (status_wr && wdata[ST_OVERFLOW]) overflow <= 1'b0;
      end
   end

   // Read mux and interrupt level, both from registered state.
   always_comb begin
      status               = 8'h00;
      status[ST_NOT_EMPTY] = !fifo_empty;
      status[ST_OVERFLOW]  = overflow;
      status[ST_IRQ_EN]    = irq_en;
      status[2:0]          = 3'(fifo_count);
      rdata                = (addr == ADDR_STATUS) ? status : (fifo_empty ? 8'h00 : fifo_dout);
      irq                  = irq_en && !fifo_empty;
   end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with SCAN_DIV=4 (16-clk sweeps), DEBOUNCE=3.
module tb_keypad_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] row;
   logic [3:0] col;
   logic       cs, rd, wr, addr;
   logic [7:0] wdata;
   logic [7:0] rdata;
   logic       irq;

   logic [15:0] keys;   // bit row*4+col = key closed
   int          cyc;
   int          n_cmp  = 0;
   int          n_fail = 0;

   typedef struct {
      logic [15:0] keys;
      int          sweeps;
      bit          do_read;
      logic [7:0]  exp_data;
      logic [7:0]  exp_status;
   } vec_t;

   vec_t vecs [23];

   keypad_scan_ctrl #(
      .SCAN_DIV   (4),
      .DEBOUNCE   (3),
      .FIFO_DEPTH (4)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .row   (row),
      .col   (col),
      .cs    (cs),
      .rd    (rd),
      .wr    (wr),
      .addr  (addr),
      .wdata (wdata),
      .rdata (rdata),
      .irq   (irq)
   );

   always #5 clk = ~clk;

   // Keypad matrix: a row reads high when a closed key sits on the driven column.
   always_comb begin
      for (int r = 0; r < 4; r++) row[r] = |(keys[r*4 +: 4] & col);
   end

   // Clocks since reset release; sweeps end on multiples of 16.
   always @(posedge clk) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic check(input logic [7:0] act, input logic [7:0] exp, input string name);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
      end
   endtask

   task automatic check_status(input logic [7:0] exp, input string name);
      addr = 1'b1;
      #1;
      check(rdata, exp, name);
   endtask

   task automatic read_data(input logic [7:0] exp, input string name);
      cs = 1'b1; rd = 1'b1; addr = 1'b0;
      #1;
      check(rdata, exp, name);
      @(negedge clk);
      cs = 1'b0; rd = 1'b0;
   endtask

   task automatic bus_write(input logic a, input logic [7:0] d);
      cs = 1'b1; wr = 1'b1; addr = a; wdata = d;
      @(negedge clk);
      cs = 1'b0; wr = 1'b0; wdata = 8'h00;
   endtask

   task automatic align();
      while (cyc % 16 != 0) @(negedge clk);
   endtask

   task automatic wait_sweeps(input int n);
      for (int i = 0; i < n; i++) begin
         do @(negedge clk); while (cyc % 16 != 0);
      end
   endtask

   task automatic press_release(input logic [15:0] k);
      align();
      keys = k;
      wait_sweeps(3);
      keys = 16'h0000;
      wait_sweeps(3);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      // keys, sweeps, read?, DATA expected, STATUS expected
      vecs[0]  = '{16'h0000, 1,  1'b0, 8'h00, 8'h00};
      vecs[1]  = '{16'h0200, 2,  1'b0, 8'h00, 8'h00};  // row2/col1, not yet confirmed
      vecs[2]  = '{16'h0200, 1,  1'b0, 8'h00, 8'h81};  // third sweep pushes 0x19
      vecs[3]  = '{16'h0200, 10, 1'b1, 8'h19, 8'h81};  // no repeat while held
      vecs[4]  = '{16'h0200, 0,  1'b0, 8'h00, 8'h00};
      vecs[5]  = '{16'h0000, 3,  1'b0, 8'h00, 8'h00};
      vecs[6]  = '{16'h0080, 2,  1'b0, 8'h00, 8'h00};  // bounce: sweeps 1,2
      vecs[7]  = '{16'h0000, 1,  1'b0, 8'h00, 8'h00};  // gap on sweep 3
      vecs[8]  = '{16'h0080, 2,  1'b0, 8'h00, 8'h00};  // sweeps 4,5
      vecs[9]  = '{16'h0080, 1,  1'b1, 8'h17, 8'h81};  // push at sweep 6
      vecs[10] = '{16'h0000, 3,  1'b0, 8'h00, 8'h00};
      vecs[11] = '{16'h4001, 4,  1'b0, 8'h00, 8'h00};  // two keys: ghost, ignored
      vecs[12] = '{16'h0000, 1,  1'b0, 8'h00, 8'h00};
      vecs[13] = '{16'h0001, 3,  1'b0, 8'h00, 8'h81};  // 0x10
      vecs[14] = '{16'h0000, 3,  1'b0, 8'h00, 8'h81};
      vecs[15] = '{16'h0020, 3,  1'b0, 8'h00, 8'h82};  // 0x15
      vecs[16] = '{16'h0000, 3,  1'b0, 8'h00, 8'h82};
      vecs[17] = '{16'h0400, 3,  1'b0, 8'h00, 8'h83};  // 0x1A
      vecs[18] = '{16'h0000, 3,  1'b0, 8'h00, 8'h83};
      vecs[19] = '{16'h8000, 3,  1'b0, 8'h00, 8'h84};  // 0x1F
      vecs[20] = '{16'h0000, 3,  1'b0, 8'h00, 8'h84};
      vecs[21] = '{16'h0008, 3,  1'b0, 8'h00, 8'hC4};  // 0x13 dropped
      vecs[22] = '{16'h0000, 3,  1'b0, 8'h00, 8'hC4};

      rst = 1'b1; keys = 16'h0000;
      cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = 1'b0; wdata = 8'h00;
      do_reset();

      // Reset state
      #1;
      check(8'(col), 8'h01, "reset col");
      check(8'(irq), 8'h00, "reset irq");
      check_status(8'h00, "reset STATUS");
      addr = 1'b0; #1;
      check(rdata, 8'h00, "reset DATA");

      // Column rotation every 4 clks
      for (int i = 1; i <= 4; i++) begin
         logic [3:0] e;
         e = 4'(1 << (i % 4));
         repeat (4) @(negedge clk);
         check(8'(col), 8'(e), $sformatf("col step %0d", i));
      end

      // Table-driven sweep scenarios
      for (int i = 0; i < 23; i++) begin
         align();
         keys = vecs[i].keys;
         wait_sweeps(vecs[i].sweeps);
         check_status(vecs[i].exp_status, $sformatf("vec%0d STATUS", i));
         if (vecs[i].do_read) read_data(vecs[i].exp_data, $sformatf("vec%0d DATA", i));
      end

      // Overflow clear, then drain in order
      bus_write(1'b1, 8'h40);
      check_status(8'h84, "ovf clear STATUS");
      read_data(8'h10, "drain0");
      read_data(8'h15, "drain1");
      read_data(8'h1A, "drain2");
      read_data(8'h1F, "drain3");
      check_status(8'h00, "drained STATUS");
      read_data(8'h00, "empty DATA");
      check_status(8'h00, "empty pop STATUS");

      // irq enable while empty
      bus_write(1'b1, 8'h20);
      check(8'(irq), 8'h00, "irq empty");
      check_status(8'h20, "irq_en STATUS");

      // irq rises the clk after the push edge
      align();
      keys = 16'h0040;
      wait_sweeps(2);
      do @(negedge clk); while (cyc % 16 != 15);
      check(8'(irq), 8'h00, "irq before push");
      @(negedge clk);
      check(8'(irq), 8'h01, "irq after push");
      check_status(8'hA1, "push0x16 STATUS");

      // Fill to four, then push with a simultaneous pop
      align();
      keys = 16'h0000;
      wait_sweeps(3);
      press_release(16'h0002);
      press_release(16'h0004);
      press_release(16'h0010);
      check_status(8'hA4, "full STATUS");
      keys = 16'h0100;
      wait_sweeps(2);
      do @(negedge clk); while (cyc % 16 != 15);
      cs = 1'b1; rd = 1'b1; addr = 1'b0;
      #1;
      check(rdata, 8'h16, "push+pop head");
      @(negedge clk);
      cs = 1'b0; rd = 1'b0;
      check_status(8'hA4, "push+pop STATUS");
      read_data(8'h11, "fifo order0");
      read_data(8'h12, "fifo order1");
      read_data(8'h14, "fifo order2");
      read_data(8'h18, "fifo order3");
      check_status(8'h20, "post drain STATUS");

      // Reset in the middle of a press debounce with a code queued
      align();
      keys = 16'h0000;
      wait_sweeps(3);
      keys = 16'h0800;
      wait_sweeps(3);
      check_status(8'hA1, "queued 0x1B STATUS");
      keys = 16'h0000;
      wait_sweeps(3);
      keys = 16'h1000;
      wait_sweeps(2);
      repeat (5) @(negedge clk);
      do_reset();
      #1;
      check(8'(col), 8'h01, "mid reset col");
      check(8'(irq), 8'h00, "mid reset irq");
      check_status(8'h00, "mid reset STATUS");
      addr = 1'b0; #1;
      check(rdata, 8'h00, "mid reset DATA");
      wait_sweeps(2);
      check_status(8'h00, "restart debounce STATUS");
      wait_sweeps(1);
      check_status(8'h81, "restart push STATUS");
      read_data(8'h1C, "restart DATA");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
